// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types and constants for the core_sequencer run controller.
// Revision : 1.0
// ============================================================================
package seq_pkg;

    localparam int SEQ_ADDR_W = 5;
    localparam int SEQ_DATA_W = 16;

    // Opcode field (top five bits) that the core treats as HALT.
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    function automatic logic [15:0] halt_word();
        return {OP_HALT, 11'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mem_mux.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_mux
// Brief    : Selects whether cpu_core or the sequencer drives the memory port.
// Revision : 1.0
// ============================================================================
module seq_mem_mux #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              own_core,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [DATA_W-1:0] seq_wdata,
    input  logic              seq_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    always_comb begin
        mem_addr  = seq_addr;
        mem_wdata = seq_wdata;
        mem_we    = seq_we;
        if (own_core) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Brief    : Loads a program image, runs cpu_core to HALT, dumps a result window.
//            Optional RUN watchdog enabled by defining SEQ_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module core_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W          = SEQ_ADDR_W,
    parameter int DATA_W          = SEQ_DATA_W,
    parameter int DUMP_BASE       = 16,
    parameter int DUMP_COUNT      = 8,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_go,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              core_reset,
    output logic              core_start,
    input  logic              core_halted,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [DATA_W-1:0] core_mem_wdata,
    input  logic              core_mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              error,
    output logic [15:0]       run_cycles
);

    localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
    localparam logic [ADDR_W-1:0] RPTR_BASE = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DUMP_COUNT - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              load_ready_q, load_ready_d;
    logic              dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              core_reset_q, core_reset_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [15:0]       run_cycles_q, run_cycles_d;
    logic [15:0]       run_next;

    logic              own_core;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_wdata;
    logic              seq_we;

`ifdef SEQ_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG_CYCLES);
`else
    logic unused_watchdog;
    assign unused_watchdog = |WATCHDOG_CYCLES;
`endif

    assign run_next = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        core_reset_d = core_reset_q;
        core_start_d = core_start_q;
        error_d      = error_q;
        run_cycles_d = run_cycles_q;

        case (state_q)
            ST_IDLE: begin
                core_reset_d = 1'b1;
                if (cmd_go) begin
                    error_d      = 1'b0;
                    run_cycles_d = 16'd0;
                    ptr_d        = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_reset_d = 1'b1;
                if (load_valid) begin
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                    // A full memory without load_last truncates the image.
                    if (load_last || ptr_q == PTR_MAX) begin
                        state_d      = ST_RUN;
                        core_reset_d = 1'b0;
                        core_start_d = 1'b1;
                        if (!load_last) begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                run_cycles_d = run_next;
                if (core_halted) begin
                    core_start_d = 1'b0;
                    rptr_d       = RPTR_BASE;
                    cnt_d        = '0;
                    dump_valid_d = 1'b0;
                    state_d      = ST_DUMP;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (run_next == WD_LIMIT) begin
                    error_d      = 1'b1;
                    core_start_d = 1'b0;
                    core_reset_d = 1'b1;
                    rptr_d       = RPTR_BASE;
                    cnt_d        = '0;
                    dump_valid_d = 1'b0;
                    state_d      = ST_DUMP;
                end
`endif
            end
            ST_DUMP: begin
                // Capture on the bubble cycle, hold until the host takes it.
                if (!dump_valid_q) begin
                    dump_data_d  = mem_rdata;
                    dump_valid_d = 1'b1;
                end else if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    rptr_d       = rptr_q + ADDR_W'(1);
                    cnt_d        = cnt_q + (ADDR_W+1)'(1);
                    if (cnt_q == LAST_CNT) begin
                        core_reset_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                core_reset_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                core_reset_d = 1'b1;
                core_start_d = 1'b0;
                dump_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        load_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            run_cycles_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            load_ready_q <= load_ready_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Sequencer-side drive: LOAD writes are combinational on the handshake.
    always_comb begin
        seq_addr  = '0;
        seq_wdata = '0;
        seq_we    = 1'b0;
        if (state_q == ST_LOAD) begin
            seq_addr  = ptr_q;
            seq_wdata = load_data;
            seq_we    = load_valid;
        end else if (state_q == ST_DUMP) begin
            seq_addr  = rptr_q;
        end
    end

    assign own_core = (state_q == ST_RUN);

    seq_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .own_core   (own_core),
        .core_addr  (core_mem_addr),
        .core_wdata (core_mem_wdata),
        .core_we    (core_mem_we),
        .seq_addr   (seq_addr),
        .seq_wdata  (seq_wdata),
        .seq_we     (seq_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we)
    );

    assign load_ready = load_ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign core_reset = core_reset_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign run_cycles = run_cycles_q;

endmodule
`default_nettype wire
